// File: rtl/uart_det_pkg.sv
// Shared types and constants for the UART pattern detector.
// Build option: UART_DET_COUNT_EN enables the saturating match counter.
package uart_det_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HUNT = 1'b1
    } det_state_t;

    localparam int BYTE_BITS = 8;
    localparam int BIDX_W    = $clog2(BYTE_BITS);

endpackage

// File: rtl/uart_pattern_detector_if.sv
// Bit-stream input and detector result bundle.
// Master is the sampler side, slave is the detector.
interface uart_pattern_detector_if
    import uart_det_pkg::*;
#(
    parameter int CNT_WIDTH = 8
);
    logic                 clear;
    logic                 data_valid;
    logic                 data_bit;
    logic                 match;
    logic [CNT_WIDTH-1:0] match_count;
    logic                 byte_valid;
    logic [BYTE_BITS-1:0] byte_data;

    modport master (
        output clear,
        output data_valid,
        output data_bit,
        input  match,
        input  match_count,
        input  byte_valid,
        input  byte_data
    );

    modport slave (
        input  clear,
        input  data_valid,
        input  data_bit,
        output match,
        output match_count,
        output byte_valid,
        output byte_data
    );
endinterface

// File: rtl/uart_byte_assembler.sv
// Reassembles LSB-first serial bits into bytes.
// byte_data holds the last completed byte until the next one.
module uart_byte_assembler
    import uart_det_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic                 i_bit,
    output logic                 o_byte_valid,
    output logic [BYTE_BITS-1:0] o_byte_data
);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTE_BITS - 1);

    logic [BYTE_BITS-1:0] r_bsr;
    logic [BIDX_W-1:0]    r_bidx;
    logic [BYTE_BITS-1:0] w_bsr_nxt;

    assign w_bsr_nxt = {i_bit, r_bsr[BYTE_BITS-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bsr        <= '0;
            r_bidx       <= '0;
            o_byte_valid <= 1'b0;
            o_byte_data  <= '0;
        end else if (i_clear) begin
            r_bsr        <= '0;
            r_bidx       <= '0;
            o_byte_valid <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            if (i_valid) begin
                r_bsr  <= w_bsr_nxt;
                r_bidx <= r_bidx + 1'b1;
                if (r_bidx == BIDX_LAST) begin
                    o_byte_valid <= 1'b1;
                    o_byte_data  <= w_bsr_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/uart_pattern_detector.sv
// Sliding-window pattern matcher with byte reassembly.
// Build option: UART_DET_COUNT_EN enables the saturating match counter.
module uart_pattern_detector
    import uart_det_pkg::*;
#(
    parameter logic [15:0] PATTERN     = 16'h00A5,
    parameter int          PATTERN_LEN = 8,
    parameter int          OVERLAP     = 1,
    parameter int          CNT_WIDTH   = 8
) (
    input logic                    clk,
    input logic                    rst,
    uart_pattern_detector_if.slave bus
);
    localparam int FILL_W = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_LEN - 1);
    localparam logic [PATTERN_LEN-1:0] PAT = PATTERN[PATTERN_LEN-1:0];

    det_state_t             r_state;
    logic [PATTERN_LEN-1:0] r_win;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_match;

    logic                   w_bit_in;
    logic [PATTERN_LEN-1:0] w_win_nxt;
    logic                   w_armed;
    logic                   w_hit;

    assign w_bit_in  = bus.data_valid & ~bus.clear;
    assign w_win_nxt = {r_win[PATTERN_LEN-2:0], bus.data_bit};
    // The bit that completes the fill is already compared.
    assign w_armed   = (r_state == S_HUNT) || (r_fill == FILL_LAST);
    assign w_hit     = w_bit_in && w_armed && (w_win_nxt == PAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_win   <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (bus.clear) begin
            r_state <= S_FILL;
            r_win   <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (bus.data_valid) begin
                r_win <= w_win_nxt;
                if (w_hit && OVERLAP == 0) begin
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end else begin
                    unique case (r_state)
                        S_FILL: begin
                            r_fill <= r_fill + 1'b1;
                            if (r_fill == FILL_LAST)
                                r_state <= S_HUNT;
                        end
                        S_HUNT: r_fill <= r_fill;
                        default: r_state <= S_FILL;
                    endcase
                end
            end
        end
    end

    assign bus.match = r_match;

`ifdef UART_DET_COUNT_EN
    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (bus.clear)
            r_count <= '0;
        else if (w_hit && r_count != {CNT_WIDTH{1'b1}})
            r_count <= r_count + 1'b1;
    end

    assign bus.match_count = r_count;
`else
    assign bus.match_count = {CNT_WIDTH{1'b0}};
`endif

    uart_byte_assembler u_bytes (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (bus.clear),
        .i_valid      (bus.data_valid),
        .i_bit        (bus.data_bit),
        .o_byte_valid (bus.byte_valid),
        .o_byte_data  (bus.byte_data)
    );

endmodule

// File: tb/tb_uart_pattern_detector.sv
// Randomized bench for uart_pattern_detector: three configurations
// share one bit stream and are checked against a queue-based model.
module tb_uart_pattern_detector;
    import uart_det_pkg::*;

`ifdef UART_DET_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic dv  = 1'b0;
    logic db  = 1'b0;

    always #5 clk = ~clk;

    uart_pattern_detector_if #(.CNT_WIDTH(8)) if_a ();
    uart_pattern_detector_if #(.CNT_WIDTH(2)) if_b ();
    uart_pattern_detector_if #(.CNT_WIDTH(8)) if_c ();

    assign if_a.clear = clr;
    assign if_a.data_valid = dv;
    assign if_a.data_bit = db;
    assign if_b.clear = clr;
    assign if_b.data_valid = dv;
    assign if_b.data_bit = db;
    assign if_c.clear = clr;
    assign if_c.data_valid = dv;
    assign if_c.data_bit = db;

    uart_pattern_detector #(
        .PATTERN(16'h00A5), .PATTERN_LEN(8),
        .OVERLAP(1), .CNT_WIDTH(8)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

    uart_pattern_detector #(
        .PATTERN(16'h000B), .PATTERN_LEN(4),
        .OVERLAP(0), .CNT_WIDTH(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    uart_pattern_detector #(
        .PATTERN(16'h000B), .PATTERN_LEN(4),
        .OVERLAP(1), .CNT_WIDTH(8)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    logic [2:0] o_m;
    logic [2:0] o_bv;
    logic [7:0] o_bd [3];
    logic [7:0] o_cnt [3];

    assign o_m = {if_c.match, if_b.match, if_a.match};
    assign o_bv = {if_c.byte_valid, if_b.byte_valid, if_a.byte_valid};
    assign o_bd[0] = if_a.byte_data;
    assign o_bd[1] = if_b.byte_data;
    assign o_bd[2] = if_c.byte_data;
    assign o_cnt[0] = if_a.match_count;
    assign o_cnt[1] = {6'd0, if_b.match_count};
    assign o_cnt[2] = if_c.match_count;

    int          m_len [3] = '{8, 4, 4};
    int          m_ov  [3] = '{1, 0, 1};
    int          m_cw  [3] = '{8, 2, 8};
    logic [15:0] m_pat [3] = '{16'h00A5, 16'h000B, 16'h000B};

    bit   hq [3][$];
    bit   bq [$];
    int   mcnt [3];
    logic [7:0] ebd;
    int   pulses [3];

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hq[i].delete();
            mcnt[i] = 0;
        end
        bq.delete();
        ebd = 8'h00;
    endtask

    task automatic step(input logic c, input logic v, input logic b);
        logic [2:0] em;
        logic       ebv;
        bit         ok;
        int         n;
        @(negedge clk);
        clr = c;
        dv  = v;
        db  = b;
        em  = '0;
        ebv = 1'b0;
        if (c) begin
            for (int i = 0; i < 3; i++) begin
                hq[i].delete();
                mcnt[i] = 0;
            end
            bq.delete();
        end else if (v) begin
            bq.push_back(b);
            if (bq.size() == 8) begin
                ebv = 1'b1;
                for (int k = 0; k < 8; k++) ebd[k] = bq[k];
                bq.delete();
            end
            for (int i = 0; i < 3; i++) begin
                hq[i].push_back(b);
                n = hq[i].size();
                if (n >= m_len[i]) begin
                    ok = 1'b1;
                    for (int j = 0; j < m_len[i]; j++)
                        if (hq[i][n - m_len[i] + j] != m_pat[i][m_len[i] - 1 - j])
                            ok = 1'b0;
                    if (ok) begin
                        em[i] = 1'b1;
                        if (mcnt[i] < (1 << m_cw[i]) - 1) mcnt[i]++;
                        if (m_ov[i] == 0) hq[i].delete();
                    end
                end
                while (hq[i].size() > 16) void'(hq[i].pop_front());
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (o_m[i]) pulses[i]++;
            chk($sformatf("match%0d", i), 32'(o_m[i]), 32'(em[i]));
            chk($sformatf("bvalid%0d", i), 32'(o_bv[i]), 32'(ebv));
            chk($sformatf("bdata%0d", i), 32'(o_bd[i]), 32'(ebd));
            chk($sformatf("count%0d", i), 32'(o_cnt[i]),
                CNT_ON != 0 ? 32'(mcnt[i]) : 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        dv  = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_match%0d", i), 32'(o_m[i]), 32'd0);
            chk($sformatf("rst_bvalid%0d", i), 32'(o_bv[i]), 32'd0);
            chk($sformatf("rst_bdata%0d", i), 32'(o_bd[i]), 32'd0);
            chk($sformatf("rst_count%0d", i), 32'(o_cnt[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int len);
        for (int k = len - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k]);
    endtask

    initial begin
        logic [15:0] seq;
        model_reset();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        do_reset();
        step(1'b0, 1'b0, 1'b0);

        // byte 0xA5 LSB-first, which is also pattern A
        seq = 16'h00A5;
        send_bits(seq, 8);
        chk("t2_byte", 32'(o_bd[0]), 32'h0000_00A5);
        chk("t2_count", 32'(o_cnt[0]), CNT_ON != 0 ? 32'd1 : 32'd0);

        // overlap on (C) versus off (B)
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        seq = 16'h005B;
        send_bits(seq, 7);
        chk("t3_pulsesC", 32'(pulses[2]), 32'd2);
        chk("t4_pulsesB", 32'(pulses[1]), 32'd1);
        chk("t3_countC", 32'(o_cnt[2]), CNT_ON != 0 ? 32'd2 : 32'd0);
        chk("t4_countB", 32'(o_cnt[1]), CNT_ON != 0 ? 32'd1 : 32'd0);

        // clear together with a bit mid-pattern
        step(1'b1, 1'b0, 1'b0);
        seq = 16'h0005;
        send_bits(seq, 3);
        step(1'b1, 1'b1, 1'b1);
        seq = 16'h003C;
        send_bits(seq, 8);
        chk("t5_byte", 32'(o_bd[0]), 32'h0000_003C);

        // counter saturation on B
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        for (int r = 0; r < 5; r++) begin
            seq = 16'h000B;
            send_bits(seq, 4);
        end
        chk("t6_pulsesB", 32'(pulses[1]), 32'd5);
        chk("t6_countB", 32'(o_cnt[1]), CNT_ON != 0 ? 32'd3 : 32'd0);

        // reset in the middle of a frame
        seq = 16'h0006;
        send_bits(seq, 3);
        do_reset();
        step(1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 3000; t++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 70,
                 1'($urandom_range(0, 1)));
            if (t == 1500) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
